// File: rtl/param_leaf_node.sv
// param_leaf_node: credit-based leaf router node.
// Each input port has a DEPTH-entry FIFO. Each output port has a credit
// counter and a round-robin arbiter over the input FIFO heads.
// Optional macro LEAF_NODE_OUT_REG_EN adds a second output register stage.
// Without it the output has a single register stage.

// Per-input FIFO. Pointers wrap explicitly at DEPTH-1, so DEPTH does not
// need to be a power of two. A write to a full FIFO is ignored, even if a
// read happens in the same cycle. The caller flags that case as an error.
module param_leaf_node_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        do_wr, do_rd;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = bump(wr_ptr_q);
    end
    if (do_rd) rd_ptr_d = bump(rd_ptr_q);
    cnt_d = cnt_q + CW'(do_wr) - CW'(do_rd);
  end

  // Control state. Reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage. It is not reset, because occupancy alone marks valid entries.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

module param_leaf_node #(
  parameter int PORTS = 5,
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PORTS-1:0]       in_data_valid,
  input  logic [PORTS*WIDTH-1:0] in_data,
  output logic [PORTS-1:0]       out_data_valid,
  output logic [PORTS*WIDTH-1:0] out_data,
  input  logic [PORTS-1:0]       downstream_credit,
  output logic [PORTS-1:0]       upstream_credit,
  output logic                   err
);
  localparam int DW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CW = $clog2(DEPTH + 1);
`ifdef LEAF_NODE_OUT_REG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  logic [PORTS-1:0][WIDTH-1:0] in_flit, head, gnt_data;
  logic [PORTS-1:0][DW-1:0]    dest;
  logic [PORTS-1:0]            fifo_empty, fifo_full, head_vld, bad, ovf, pop;
  logic [PORTS-1:0][PORTS-1:0] req, gnt;   // [output][input]
  logic [PORTS-1:0]            out_gnt;

  logic [PORTS-1:0][CW-1:0]    cred_q, cred_d;
  logic [PORTS-1:0]            cred_ovf;
  logic [PORTS-1:0][DW-1:0]    rr_q, rr_d;
  logic [PORTS-1:0]            ucred_q, ucred_d;
  logic                        err_q, err_d;
  logic [STAGES:1][PORTS-1:0]            vld_pipe_q, vld_pipe_d;
  logic [STAGES:1][PORTS-1:0][WIDTH-1:0] dat_pipe_q, dat_pipe_d;

  assign in_flit = in_data;

  // Per-input lanes: FIFO, head decode, bad-destination and overflow detect.
  for (genvar i = 0; i < PORTS; i++) begin : g_in
    param_leaf_node_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (in_data_valid[i]),
      .wr_data (in_flit[i]),
      .rd_en   (pop[i]),
      .rd_data (head[i]),
      .empty   (fifo_empty[i]),
      .full    (fifo_full[i])
    );
    assign head_vld[i] = !fifo_empty[i];
    assign dest[i]     = head[i][WIDTH-1 -: DW];
    assign bad[i]      = head_vld[i] && ({1'b0, dest[i]} >= (DW + 1)'(PORTS));
    assign ovf[i]      = in_data_valid[i] && fifo_full[i];
  end

  // Request matrix: each valid, routable head requests its destination.
  always_comb begin
    req = '0;
    for (int o = 0; o < PORTS; o++)
      for (int i = 0; i < PORTS; i++)
        req[o][i] = head_vld[i] && !bad[i] && (dest[i] == DW'(o));
  end

  // Round-robin arbitration per output. An output is granted only when it
  // has credit. On a grant, the pointer moves to one past the winner.
  always_comb begin
    logic found;
    int   idx;
    gnt  = '0;
    rr_d = rr_q;
    for (int o = 0; o < PORTS; o++) begin
      found = 1'b0;
      idx   = 0;
      if (cred_q[o] != '0) begin
        for (int k = 0; k < PORTS; k++) begin
          idx = int'(rr_q[o]) + k;
          if (idx >= PORTS) idx = idx - PORTS;
          if (!found && req[o][idx]) begin
            found       = 1'b1;
            gnt[o][idx] = 1'b1;
            rr_d[o]     = (idx == PORTS - 1) ? '0 : DW'(idx + 1);
          end
        end
      end
    end
  end

  // Pop winners and bad-destination heads, and steer the winning data.
  always_comb begin
    pop      = bad;
    out_gnt  = '0;
    gnt_data = '0;
    for (int o = 0; o < PORTS; o++)
      for (int i = 0; i < PORTS; i++)
        if (gnt[o][i]) begin
          pop[i]      = 1'b1;
          out_gnt[o]  = 1'b1;
          gnt_data[o] = head[i];
        end
  end

  // Credit counters: a grant decrements, a returned credit increments, and
  // both together cancel. A credit returned while already full saturates.
  always_comb begin
    cred_d   = cred_q;
    cred_ovf = '0;
    for (int o = 0; o < PORTS; o++) begin
      if (out_gnt[o] && !downstream_credit[o]) begin
        cred_d[o] = cred_q[o] - 1'b1;
      end else if (!out_gnt[o] && downstream_credit[o]) begin
        if (cred_q[o] == CW'(DEPTH)) cred_ovf[o] = 1'b1;
        else                         cred_d[o]   = cred_q[o] + 1'b1;
      end
    end
  end

  // Output pipeline, upstream credit pulses and the sticky error flag.
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    dat_pipe_d    = dat_pipe_q;
    vld_pipe_d[1] = out_gnt;
    dat_pipe_d[1] = gnt_data;
    for (int s = 2; s <= STAGES; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      dat_pipe_d[s] = dat_pipe_q[s-1];
    end
    ucred_d = pop;
    err_d   = err_q || (|ovf) || (|bad) || (|cred_ovf);
  end

  // State registers. Reset drops in-flight flits and pending credit pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < PORTS; o++) cred_q[o] <= CW'(DEPTH);
      rr_q       <= '0;
      ucred_q    <= '0;
      err_q      <= 1'b0;
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      cred_q     <= cred_d;
      rr_q       <= rr_d;
      ucred_q    <= ucred_d;
      err_q      <= err_d;
      vld_pipe_q <= vld_pipe_d;
      dat_pipe_q <= dat_pipe_d;
    end
  end

  assign out_data_valid  = vld_pipe_q[STAGES];
  assign out_data        = dat_pipe_q[STAGES];
  assign upstream_credit = ucred_q;
  assign err             = err_q;
endmodule

// File: tb/tb_param_leaf_node.sv
// Scoreboard bench for param_leaf_node (PORTS=5, WIDTH=32, DEPTH=4).
// Stimulus pushes expected flits into a queue. A negedge monitor pops and
// compares them per output, in order.
module tb_param_leaf_node;
  localparam int PORTS = 5;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
`ifdef LEAF_NODE_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                   clk;
  logic                   rst_n;
  logic [PORTS-1:0]       in_data_valid, out_data_valid;
  logic [PORTS-1:0]       downstream_credit, upstream_credit, auto_ret, man_ret;
  logic [PORTS*WIDTH-1:0] in_data, out_data;
  logic                   err;

  assign downstream_credit = auto_ret | man_ret;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ucred_cnt[PORTS] = '{default: 0};
  int dlv_cnt[PORTS]   = '{default: 0};
  bit auto_en;

  typedef struct {
    int               port;
    logic [WIDTH-1:0] data;
    int               due;   // monitor cycle the flit must be seen in, -1 = any
  } exp_t;
  exp_t expq[$];

  param_leaf_node #(.PORTS(PORTS), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_data_valid     (in_data_valid),
    .in_data           (in_data),
    .out_data_valid    (out_data_valid),
    .out_data          (out_data),
    .downstream_credit (downstream_credit),
    .upstream_credit   (upstream_credit),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare deliveries, count credit pulses, and optionally act as
  // a sink that returns one credit per delivered flit.
  always @(negedge clk) begin
    int hit;
    if (rst_n) begin
      for (int o = 0; o < PORTS; o++) begin
        ucred_cnt[o] += int'(upstream_credit[o]);
        if (out_data_valid[o]) begin
          dlv_cnt[o]++;
          hit = -1;
          for (int k = 0; k < expq.size(); k++)
            if (hit < 0 && expq[k].port == o) hit = k;
          total++;
          if (hit < 0) begin
            bad++;
            $display("FAIL unexpected_out port=%0d got=%h required=none", o, out_data[o*WIDTH +: WIDTH]);
          end else begin
            if (out_data[o*WIDTH +: WIDTH] !== expq[hit].data) begin
              bad++;
              $display("FAIL out_data port=%0d got=%h required=%h", o, out_data[o*WIDTH +: WIDTH], expq[hit].data);
            end
            if (expq[hit].due >= 0) begin
              total++;
              if (cyc != expq[hit].due) begin
                bad++;
                $display("FAIL latency port=%0d got_cycle=%0d required=%0d", o, cyc, expq[hit].due);
              end
            end
            expq.delete(hit);
          end
        end
      end
    end
    auto_ret <= (auto_en && rst_n) ? out_data_valid : '0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [PORTS*WIDTH-1:0] put(input int p, input logic [WIDTH-1:0] d);
    logic [PORTS*WIDTH-1:0] r;
    r = '0;
    r[p*WIDTH +: WIDTH] = d;
    return r;
  endfunction

  // Present one cycle of input. On return, cyc equals the sampling edge.
  task automatic drive(input logic [PORTS-1:0] v, input logic [PORTS*WIDTH-1:0] d);
    in_data_valid = v;
    in_data       = d;
    tick(1);
    in_data_valid = '0;
  endtask

  task automatic expect_flit(input int p, input logic [WIDTH-1:0] d, input int due);
    exp_t e;
    e.port = p;
    e.data = d;
    e.due  = due;
    expq.push_back(e);
  endtask

  task automatic credit(input int o);
    man_ret[o] = 1'b1;
    tick(1);
    man_ret[o] = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    check(name, expq.size(), 0);
    expq.delete();
    tick(3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int u0, u1, d0, d4, s0;
    in_data_valid = '0;
    in_data       = '0;
    man_ret       = '0;
    auto_en       = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_data_valid, 0);
    check("rst_out_data", |out_data, 0);
    check("rst_ucred", upstream_credit, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    // Single flit from port 0 to port 4. A flit sampled at edge k is held on
    // the output after edge k+LAT-1, so a receiver captures it at edge k+LAT.
    u0 = ucred_cnt[0];
    drive(5'b00001, put(0, 32'h8000_00AB));
    expect_flit(4, 32'h8000_00AB, cyc + LAT - 1);
    tick(6);
    check("t1_ucred0", ucred_cnt[0] - u0, 1);
    drain("t1_drain");

    // Ports 1 and 2 both target port 3. Output 3 must alternate 1,2,1,2,1,2.
    auto_en = 1'b1;
    s0 = cyc + 1;
    for (int j = 0; j < 3; j++) begin
      drive(5'b00110, put(1, 32'h6000_0010 + j) | put(2, 32'h6000_0020 + j));
      expect_flit(3, 32'h6000_0010 + j, s0 + LAT - 1 + 2*j);
      expect_flit(3, 32'h6000_0020 + j, s0 + LAT + 2*j);
    end
    drain("t2_drain");
    auto_en = 1'b0;
    tick(3);

    // Six flits to port 3 with no credit return: 4 go out, then one per credit.
    d0 = dlv_cnt[3];
    for (int j = 0; j < 6; j++) begin
      drive(5'b00001, put(0, 32'h6000_0030 + j));
      expect_flit(3, 32'h6000_0030 + j, -1);
    end
    tick(10);
    check("t3_stall_at_4", dlv_cnt[3] - d0, 4);
    credit(3);
    tick(6);
    check("t3_one_more", dlv_cnt[3] - d0, 5);
    credit(3);
    drain("t3_drain");
    repeat (4) credit(3);
    check("t3_err_clear", err, 0);

    // A destination field of 7 is unroutable: the flit is dropped, its credit
    // is still returned, and err is raised and stays set.
    u1 = ucred_cnt[1];
    drive(5'b00010, put(1, 32'hE000_0012));
    tick(6);
    check("t4_ucred1", ucred_cnt[1] - u1, 1);
    check("t4_err", err, 1);
    tick(5);
    check("t4_err_sticky", err, 1);

    // Starve output 4, then push 5 flits into port 0. The fifth is dropped.
    do_reset();
    check("t5_err_after_rst", err, 0);
    for (int j = 0; j < 4; j++) begin
      drive(5'b00100, put(2, 32'h8000_0040 + j));
      expect_flit(4, 32'h8000_0040 + j, -1);
    end
    drain("t5_starve_drain");
    u0 = ucred_cnt[0];
    for (int j = 0; j < 4; j++) begin
      drive(5'b00001, put(0, 32'h8000_0050 + j));
      expect_flit(4, 32'h8000_0050 + j, -1);
    end
    tick(1);
    check("t5_err_before_full", err, 0);
    drive(5'b00001, put(0, 32'h8000_0054));
    check("t5_err_overflow", err, 1);
    repeat (4) credit(4);
    drain("t5_drain");
    credit(4);
    tick(8);
    check("t5_ucred0", ucred_cnt[0] - u0, 4);

    // Reset with two buffered flits and one delivery in flight.
    do_reset();
    for (int j = 0; j < 4; j++) begin
      drive(5'b00100, put(2, 32'h8000_0070 + j));
      expect_flit(4, 32'h8000_0070 + j, -1);
    end
    drain("t6_starve_drain");
    drive(5'b00001, put(0, 32'h8000_0060));
    drive(5'b00001, put(0, 32'h8000_0061));
    tick(2);
    u0 = ucred_cnt[0];
    d4 = dlv_cnt[4];
    credit(4);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_data_valid, 0);
    check("t6_rst_data", |out_data, 0);
    check("t6_rst_ucred", upstream_credit, 0);
    check("t6_rst_err", err, 0);
    tick(2);
    rst_n = 1'b1;
    tick(12);
    check("t6_no_delivery", dlv_cnt[4] - d4, 0);
    check("t6_no_ucred", ucred_cnt[0] - u0, 0);

    // A credit returned to a full counter saturates it and raises err.
    check("t7_err_pre", err, 0);
    credit(2);
    check("t7_err_credit_ovf", err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
